// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions used by both the receiver and the transmitter:
// the frame-level state encoding and the oversampling constants derived from
// the 16x baud tick.
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    // Frame-level state shared by the receiver and transmitter FSMs
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Number of s_tick strobes per bit period
    localparam int OVERSAMPLE = 16;

    // Tick index at the middle of the start bit (8th tick, counting from 0)
    localparam int START_MID  = OVERSAMPLE / 2 - 1;

    // Tick index of the last tick of a full bit period
    localparam int BIT_LAST   = OVERSAMPLE - 1;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial input, baud tick and received-data outputs of the UART
// receiver.
//   rx           serial line, idle high (driven by master)
//   s_tick       16x baud strobe (driven by master)
//   rx_done_tick one-clk strobe, frame complete (driven by slave)
//   dout         received data word (driven by slave)
//   framing_err  stop bit sampled low on last frame (driven by slave)
// DBIT must match the DBIT parameter of the uart_rx instance it is bound to.
// ----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DBIT = 8
);

    logic            rx;
    logic            s_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] dout;
    logic            framing_err;

    // Side that drives the line and the tick, and consumes the data
    modport master (
        output rx,
        output s_tick,
        input  rx_done_tick,
        input  dout,
        input  framing_err
    );

    // The receiver itself
    modport slave (
        input  rx,
        input  s_tick,
        output rx_done_tick,
        output dout,
        output framing_err
    );

endinterface : uart_rx_if

// File: rtl/uart_rx_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. Output lags the
// input by two clock cycles. Reusable for button and serial-line inputs.
//   clk    system clock
//   reset  synchronous active-high reset; both flops load RESET_VAL
//   d      asynchronous input
//   q      synchronized output
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage shift chain; the first stage may go metastable
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver with 16x oversampling. The serial line is synchronized, the
// start bit is validated at its midpoint, each data bit is sampled at its
// midpoint (LSB first) and the stop bit is checked for a framing error.
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    uart_rx_if.slave: rx, s_tick in; rx_done_tick, dout, framing_err out
// Parameters:
//   DBIT     data bits per frame
//   SB_TICK  stop length in s_tick units (16/24/32 = 1/1.5/2 stop bits)
// ----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    // Bit counter width; kept at least one bit wide for DBIT == 1
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    // Tick counter is 4 bits for a 16x bit period, widened only when the
    // stop length needs more range (1.5 or 2 stop bits)
    localparam int SW = ($clog2(SB_TICK) > $clog2(OVERSAMPLE)) ?
                        $clog2(SB_TICK) : $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] S_START_MID = SW'(START_MID);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(BIT_LAST);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    logic            rx_s;

    uart_state_e     state_r;
    uart_state_e     state_next_s;
    logic [SW-1:0]   s_r;
    logic [SW-1:0]   s_next_s;
    logic [NW-1:0]   n_r;
    logic [NW-1:0]   n_next_s;
    logic [DBIT-1:0] b_r;
    logic [DBIT-1:0] b_next_s;
    logic            done_r;
    logic            done_next_s;
    logic            ferr_r;
    logic            ferr_next_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            s_r     <= '0;
            n_r     <= '0;
            b_r     <= '0;
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            s_r     <= s_next_s;
            n_r     <= n_next_s;
            b_r     <= b_next_s;
            done_r  <= done_next_s;
            ferr_r  <= ferr_next_s;
        end
    end

    // Next-state and datapath logic; without s_tick everything but IDLE holds
    always_comb begin
        state_next_s = state_r;
        s_next_s     = s_r;
        n_next_s     = n_r;
        b_next_s     = b_r;
        done_next_s  = 1'b0;
        ferr_next_s  = ferr_r;

        case (state_r)
            IDLE: begin
                // Falling edge detection runs on every clk, not on ticks, so
                // a start bit right after STOP is picked up immediately
                if (!rx_s) begin
                    state_next_s = START;
                    s_next_s     = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end

            START: begin
                if (bus.s_tick) begin
                    if (s_r == S_START_MID) begin
                        // Line must still be low at mid start bit, else glitch
                        if (!rx_s) begin
                            state_next_s = DATA;
                            s_next_s     = '0;
                            n_next_s     = '0;
                        end else begin
                            state_next_s = IDLE;
                            s_next_s     = '0;
                        end
                    end else begin
                        s_next_s = s_r + SW'(1);
                    end
                end else begin
                    s_next_s = s_r;
                end
            end

            DATA: begin
                if (bus.s_tick) begin
                    if (s_r == S_BIT_LAST) begin
                        // Mid-bit sample, shifted in from the MSB (LSB first)
                        b_next_s = {rx_s, b_r[DBIT-1:1]};
                        s_next_s = '0;
                        if (n_r == N_LAST) begin
                            state_next_s = STOP;
                        end else begin
                            n_next_s = n_r + NW'(1);
                        end
                    end else begin
                        s_next_s = s_r + SW'(1);
                    end
                end else begin
                    s_next_s = s_r;
                end
            end

            STOP: begin
                if (bus.s_tick) begin
                    if (s_r == S_STOP_LAST) begin
                        // Data is delivered even on a framing error
                        done_next_s  = 1'b1;
                        ferr_next_s  = ~rx_s;
                        state_next_s = IDLE;
                        s_next_s     = '0;
                    end else begin
                        s_next_s = s_r + SW'(1);
                    end
                end else begin
                    s_next_s = s_r;
                end
            end

            default: begin
                state_next_s = IDLE;
                s_next_s     = '0;
                n_next_s     = '0;
            end
        endcase
    end

    assign bus.rx_done_tick = done_r;
    assign bus.dout         = b_r;
    assign bus.framing_err  = ferr_r;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx: s_tick every 4 clk, so one bit is 64 clk.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic clk;
    logic reset;
    logic tick_en;
    int   tick_cnt;

    int   checks;
    int   errors;

    int         done_cnt;
    logic [7:0] cap_data [0:15];
    logic       cap_ferr [0:15];

    uart_rx_if #(.DBIT(8)) u_if ();

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick source: one-clk strobe every 4 clk, freezable
    initial begin
        tick_cnt    = 0;
        u_if.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                if (tick_cnt == 3) begin
                    u_if.s_tick = 1'b1;
                    tick_cnt    = 0;
                end else begin
                    u_if.s_tick = 1'b0;
                    tick_cnt    = tick_cnt + 1;
                end
            end else begin
                u_if.s_tick = 1'b0;
            end
        end
    end

    // Strobe monitor: records every rx_done_tick cycle with its data
    initial done_cnt = 0;
    always @(negedge clk) begin
        if (u_if.rx_done_tick === 1'b1) begin
            cap_data[done_cnt[3:0]] <= u_if.dout;
            cap_ferr[done_cnt[3:0]] <= u_if.framing_err;
            done_cnt                <= done_cnt + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            u_if.rx = d[i];
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
        u_if.rx = 1'b0;
        wait_clk(BIT_CLK);
        send_bits(d, 0, 7);
        u_if.rx = stop_val;
        wait_clk(stop_len);
        u_if.rx = 1'b1;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        u_if.rx = 1'b1;
        wait_clk(5);
        checks++;
        if (u_if.rx_done_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", u_if.rx_done_tick);
        end
        checks++;
        if (u_if.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h want 00", u_if.dout);
        end
        checks++;
        if (u_if.framing_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr got %b want 0", u_if.framing_err);
        end
        reset = 1'b0;
        wait_clk(40);
    endtask

    task automatic test_basic;
        int base;
        base = done_cnt;
        send_frame(8'h55, 1'b1, BIT_CLK);
        wait_clk(20);
        checks++;
        if (done_cnt - base !== 1) begin
            errors++;
            $display("FAIL basic_strobes got %0d want 1", done_cnt - base);
        end
        checks++;
        if (cap_data[base[3:0]] !== 8'h55) begin
            errors++;
            $display("FAIL basic_dout got %h want 55", cap_data[base[3:0]]);
        end
        checks++;
        if (cap_ferr[base[3:0]] !== 1'b0) begin
            errors++;
            $display("FAIL basic_ferr got %b want 0", cap_ferr[base[3:0]]);
        end
    endtask

    task automatic test_framing;
        int base;
        base = done_cnt;
        // Stop bit low just past its midpoint, then line released high
        send_frame(8'hA3, 1'b0, 40);
        wait_clk(3 * BIT_CLK);
        checks++;
        if (done_cnt - base !== 1) begin
            errors++;
            $display("FAIL ferr_strobes got %0d want 1", done_cnt - base);
        end
        checks++;
        if (cap_data[base[3:0]] !== 8'hA3) begin
            errors++;
            $display("FAIL ferr_dout got %h want a3", cap_data[base[3:0]]);
        end
        checks++;
        if (cap_ferr[base[3:0]] !== 1'b1) begin
            errors++;
            $display("FAIL ferr_flag got %b want 1", cap_ferr[base[3:0]]);
        end
        checks++;
        if (u_if.framing_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_hold got %b want 1", u_if.framing_err);
        end
    endtask

    task automatic test_glitch;
        int base;
        base = done_cnt;
        u_if.rx = 1'b0;
        wait_clk(20);
        u_if.rx = 1'b1;
        wait_clk(200);
        checks++;
        if (done_cnt - base !== 0) begin
            errors++;
            $display("FAIL glitch_strobes got %0d want 0", done_cnt - base);
        end
        send_frame(8'h0F, 1'b1, BIT_CLK);
        wait_clk(20);
        checks++;
        if (done_cnt - base !== 1) begin
            errors++;
            $display("FAIL glitch_next_strobes got %0d want 1", done_cnt - base);
        end
        checks++;
        if (cap_data[base[3:0]] !== 8'h0F) begin
            errors++;
            $display("FAIL glitch_next_dout got %h want 0f", cap_data[base[3:0]]);
        end
        checks++;
        if (cap_ferr[base[3:0]] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_next_ferr got %b want 0", cap_ferr[base[3:0]]);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        base = done_cnt;
        send_frame(8'h00, 1'b1, BIT_CLK);
        send_frame(8'hFF, 1'b1, BIT_CLK);
        wait_clk(20);
        checks++;
        if (done_cnt - base !== 2) begin
            errors++;
            $display("FAIL b2b_strobes got %0d want 2", done_cnt - base);
        end
        checks++;
        if (cap_data[base[3:0]] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first got %h want 00", cap_data[base[3:0]]);
        end
        checks++;
        if (cap_data[(base + 1) % 16] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second got %h want ff", cap_data[(base + 1) % 16]);
        end
    endtask

    task automatic test_reset_midframe;
        int base;
        base = done_cnt;
        u_if.rx = 1'b0;
        wait_clk(BIT_CLK);
        send_bits(8'h3C, 0, 3);
        u_if.rx = 1'b1;            // bit 4 of 0x3C
        wait_clk(BIT_CLK / 2);
        reset = 1'b1;
        wait_clk(3);
        checks++;
        if (u_if.dout !== 8'h00) begin
            errors++;
            $display("FAIL midrst_dout got %h want 00", u_if.dout);
        end
        reset = 1'b0;
        wait_clk(2 * BIT_CLK);
        checks++;
        if (done_cnt - base !== 0) begin
            errors++;
            $display("FAIL midrst_aborted got %0d want 0", done_cnt - base);
        end
        send_frame(8'h81, 1'b1, BIT_CLK);
        wait_clk(20);
        checks++;
        if (done_cnt - base !== 1) begin
            errors++;
            $display("FAIL midrst_strobes got %0d want 1", done_cnt - base);
        end
        checks++;
        if (cap_data[base[3:0]] !== 8'h81) begin
            errors++;
            $display("FAIL midrst_dout_next got %h want 81", cap_data[base[3:0]]);
        end
    endtask

    task automatic test_tick_freeze;
        int base;
        base = done_cnt;
        u_if.rx = 1'b0;
        wait_clk(BIT_CLK);
        send_bits(8'h96, 0, 2);
        u_if.rx = 1'b0;            // bit 3 of 0x96
        wait_clk(20);
        tick_en = 1'b0;
        wait_clk(200);
        // Bits 0..2 (0,1,1) shifted into the previous word 0x81
        checks++;
        if (u_if.dout !== 8'hD0) begin
            errors++;
            $display("FAIL freeze_partial got %h want d0", u_if.dout);
        end
        checks++;
        if (done_cnt - base !== 0) begin
            errors++;
            $display("FAIL freeze_strobes got %0d want 0", done_cnt - base);
        end
        tick_en = 1'b1;
        wait_clk(BIT_CLK - 20);
        send_bits(8'h96, 4, 7);
        u_if.rx = 1'b1;
        wait_clk(BIT_CLK + 20);
        checks++;
        if (done_cnt - base !== 1) begin
            errors++;
            $display("FAIL freeze_done got %0d want 1", done_cnt - base);
        end
        checks++;
        if (cap_data[base[3:0]] !== 8'h96) begin
            errors++;
            $display("FAIL freeze_dout got %h want 96", cap_data[base[3:0]]);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        tick_en = 1'b1;
        reset   = 1'b1;
        u_if.rx = 1'b1;
        test_reset();
        test_basic();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_tick_freeze();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
